// File: rtl/register_file_pkg.sv
// register_file_pkg
// Shared constants for the register file and its read ports: default data and
// address widths, the number of architectural registers, and the address of
// the hardwired zero register.
package register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Register 0 is hardwired to zero and never holds written data.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One combinational read path of the register file. Selects a word from the
// storage array, forces address 0 to read as zero and, when the build macro
// REGFILE_BYPASS_EN is defined, forwards the in-flight write data when the
// read address matches the committing write address.
//
// Ports:
//   regs_i     storage array (NUM_REGS words of DATA_W bits)
//   rd_addr_i  read address
//   wr_en_i    a write will commit on the next rising edge
//   wr_addr_i  address of that write
//   wr_data_i  data of that write
//   rd_data_o  read result
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // Address 0 always reads zero, whatever the array holds.
  always_comb begin
    rd_data_o = '0;
    if (rd_addr_i != ADDR_W'(REG_ZERO)) begin
      rd_data_o = regs_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
      // Write-through: wr_en_i is only set for non-zero addresses out of reset.
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_o = wr_data_i;
      end
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  // Without forwarding the write-side inputs are intentionally left unused.
  logic unused_wr_sink;
  assign unused_wr_sink = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

endmodule

// File: rtl/register_file.sv
// register_file
// Two-read, one-write register file with an extra debug read port and a count
// of committed writes. Register 0 reads as zero and ignores writes. Reads are
// combinational; writes commit on the rising edge of Clk. Rst is asynchronous
// and active-low and clears every register and the write counter.
//
// Optional build macro: REGFILE_BYPASS_EN -- when defined, a read of the
// address being written returns the new data in the same cycle.
//
// Ports:
//   Clk, Rst             clock, async active-low reset
//   regWrite             write enable
//   writeReg, writeData  write address and data
//   readReg1/readData1   read port 1
//   readReg2/readData2   read port 2
//   dbgReg/dbgData       debug read port
//   writeCount           committed writes since reset (wraps at 16 bits)
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic [ADDR_W-1:0] dbgReg,
  output logic [DATA_W-1:0] dbgData,
  output logic [15:0]       writeCount
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [15:0]       count_q;
  logic [15:0]       count_d;
  logic              commit;

  // A write commits only out of reset and never to the zero register; gating
  // with Rst also keeps forwarded data off the read ports during reset.
  assign commit = regWrite && Rst && (writeReg != ADDR_W'(REG_ZERO));

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (commit) begin
      regs_d[writeReg] = writeData;
      count_d          = count_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  assign writeCount = count_q;

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .regs_i    (regs_q),
    .rd_addr_i (readReg1),
    .wr_en_i   (commit),
    .wr_addr_i (writeReg),
    .wr_data_i (writeData),
    .rd_data_o (readData1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .regs_i    (regs_q),
    .rd_addr_i (readReg2),
    .wr_en_i   (commit),
    .wr_addr_i (writeReg),
    .wr_data_i (writeData),
    .rd_data_o (readData2)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
    .regs_i    (regs_q),
    .rd_addr_i (dbgReg),
    .wr_en_i   (commit),
    .wr_addr_i (writeReg),
    .wr_data_i (writeData),
    .rd_data_o (dbgData)
  );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
// Directed-vector bench for register_file. Each scenario task drives its own
// stimulus and compares against hand-computed values. Expectations for the
// same-cycle read of a written address follow REGFILE_BYPASS_EN.
module tb_register_file;

  logic        Clk;
  logic        Rst;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [4:0]  dbgReg;
  logic [31:0] dbgData;
  logic [15:0] writeCount;

  int checks = 0;
  int errors = 0;
  logic [15:0] expCount = 16'd0;

  register_file dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .regWrite   (regWrite),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .readReg1   (readReg1),
    .readReg2   (readReg2),
    .readData1  (readData1),
    .readData2  (readData2),
    .dbgReg     (dbgReg),
    .dbgData    (dbgData),
    .writeCount (writeCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance past the next rising edge; outputs are then sampled away from it.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic test_reset();
    Rst = 1'b0; regWrite = 1'b0; writeReg = 5'd0; writeData = 32'h0;
    readReg1 = 5'd5; readReg2 = 5'd7; dbgReg = 5'd31;
    #3;
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0 || dbgData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_reads got %h %h %h want 0", readData1, readData2, dbgData);
    end
    checks++;
    if (writeCount !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_count got %h want 0", writeCount);
    end
    Rst = 1'b1;
    tick();
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
    tick();
    regWrite = 1'b0;
    #1;
    checks++;
    if (readData1 !== 32'hDEADBEEF || writeCount !== 16'd1) begin
      errors++;
      $display("[TB] FAIL pre_reset_write got %h/%h want deadbeef/0001", readData1, writeCount);
    end
    // Mid-cycle asynchronous reset.
    Rst = 1'b0;
    #1;
    checks++;
    if (readData1 !== 32'h0 || writeCount !== 16'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got %h/%h want 0/0", readData1, writeCount);
    end
    // A write presented while reset is held is lost and not forwarded.
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'h00000055;
    #1;
    checks++;
    if (readData1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_no_forward got %h want 0", readData1);
    end
    tick();
    checks++;
    if (readData1 !== 32'h0 || writeCount !== 16'h0) begin
      errors++;
      $display("[TB] FAIL write_in_reset got %h/%h want 0/0", readData1, writeCount);
    end
    // Release mid-cycle; first edge with Rst=1 commits.
    Rst = 1'b1;
    tick();
    regWrite = 1'b0;
    #1;
    checks++;
    if (readData1 !== 32'h00000055 || writeCount !== 16'd1) begin
      errors++;
      $display("[TB] FAIL first_write_after_reset got %h/%h want 00000055/0001", readData1, writeCount);
    end
    expCount = 16'd1;
  endtask

  task automatic test_write_read();
    regWrite = 1'b1; writeReg = 5'd8; writeData = 32'h12345678;
    tick();
    regWrite = 1'b0; writeData = 32'h0;
    readReg1 = 5'd8; readReg2 = 5'd8; dbgReg = 5'd8;
    expCount = expCount + 16'd1;
    #1;
    checks++;
    if (readData1 !== 32'h12345678 || readData2 !== 32'h12345678 || dbgData !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL write_read got %h %h %h want 12345678", readData1, readData2, dbgData);
    end
    checks++;
    if (writeCount !== expCount) begin
      errors++;
      $display("[TB] FAIL write_read_count got %h want %h", writeCount, expCount);
    end
  endtask

  task automatic test_zero_reg();
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF;
    readReg1 = 5'd0; readReg2 = 5'd0; dbgReg = 5'd0;
    #1;
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0 || dbgData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL zero_reg_same_cycle got %h %h %h want 0", readData1, readData2, dbgData);
    end
    tick();
    regWrite = 1'b0;
    #1;
    checks++;
    if (readData1 !== 32'h0 || writeCount !== expCount) begin
      errors++;
      $display("[TB] FAIL zero_reg got %h/%h want 0/%h", readData1, writeCount, expCount);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] expBefore;
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h1;
    tick();
    expCount = expCount + 16'd1;
    writeData = 32'h2; readReg1 = 5'd3; readReg2 = 5'd3; dbgReg = 5'd8;
`ifdef REGFILE_BYPASS_EN
    expBefore = 32'h2;
`else
    expBefore = 32'h1;
`endif
    #1;
    checks++;
    if (readData1 !== expBefore || readData2 !== expBefore) begin
      errors++;
      $display("[TB] FAIL same_cycle_before got %h %h want %h", readData1, readData2, expBefore);
    end
    checks++;
    if (dbgData !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL same_cycle_other_addr got %h want 12345678", dbgData);
    end
    tick();
    regWrite = 1'b0;
    expCount = expCount + 16'd1;
    #1;
    checks++;
    if (readData1 !== 32'h2 || writeCount !== expCount) begin
      errors++;
      $display("[TB] FAIL same_cycle_after got %h/%h want 00000002/%h", readData1, writeCount, expCount);
    end
  endtask

  task automatic test_back_to_back();
    regWrite = 1'b1;
    writeReg = 5'd10; writeData = 32'hA0A0A0A0;
    tick();
    writeReg = 5'd11; writeData = 32'hB1B1B1B1;
    tick();
    writeReg = 5'd31; writeData = 32'hC3C3C3C3;
    tick();
    regWrite = 1'b0;
    expCount = expCount + 16'd3;
    readReg1 = 5'd10; readReg2 = 5'd11; dbgReg = 5'd31;
    #1;
    checks++;
    if (readData1 !== 32'hA0A0A0A0 || readData2 !== 32'hB1B1B1B1 || dbgData !== 32'hC3C3C3C3) begin
      errors++;
      $display("[TB] FAIL back_to_back got %h %h %h want a0a0a0a0 b1b1b1b1 c3c3c3c3", readData1, readData2, dbgData);
    end
    checks++;
    if (writeCount !== expCount) begin
      errors++;
      $display("[TB] FAIL back_to_back_count got %h want %h", writeCount, expCount);
    end
  endtask

  task automatic test_hold();
    regWrite = 1'b0;
    for (int i = 0; i < 10; i++) begin
      writeData = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h0;
      writeReg  = 5'(i + 3);
      tick();
    end
    readReg1 = 5'd3; readReg2 = 5'd5; dbgReg = 5'd8;
    #1;
    checks++;
    if (readData1 !== 32'h2 || readData2 !== 32'h55 || dbgData !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL hold_regs got %h %h %h want 00000002 00000055 12345678", readData1, readData2, dbgData);
    end
    checks++;
    if (writeCount !== expCount) begin
      errors++;
      $display("[TB] FAIL hold_count got %h want %h", writeCount, expCount);
    end
  endtask

  task automatic test_wrap();
    Rst = 1'b0;
    #1;
    Rst = 1'b1;
    regWrite = 1'b1; writeReg = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      writeData = i;
      tick();
    end
    checks++;
    if (writeCount !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL wrap_max got %h want ffff", writeCount);
    end
    writeData = 32'h0000FFFF;
    tick();
    regWrite = 1'b0;
    readReg1 = 5'd1;
    #1;
    checks++;
    if (writeCount !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap_zero got %h want 0000", writeCount);
    end
    checks++;
    if (readData1 !== 32'h0000FFFF) begin
      errors++;
      $display("[TB] FAIL wrap_last_data got %h want 0000ffff", readData1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_cycle();
    test_back_to_back();
    test_hold();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W (32 registers).
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  asynchronous, active-low reset.
REQ-005 regWrite  input  1  write enable for the write port.
REQ-006 writeReg  input  ADDR_W  write address, driven by the 5-bit 2:1 destination-register mux.
REQ-007 writeData  input  DATA_W  write-back data.
REQ-008 readReg1  input  ADDR_W  read-port-1 address (rs).
REQ-009 readReg2  input  ADDR_W  read-port-2 address (rt).
REQ-010 readData1  output  DATA_W  contents of register readReg1.
REQ-011 readData2  output  DATA_W  contents of register readReg2.
REQ-012 dbgReg  input  ADDR_W  debug/board-display read address.
REQ-013 dbgData  output  DATA_W  contents of register dbgReg.
REQ-014 writeCount  output  16  number of committed writes since reset.

Function
REQ-015 One clock domain and one reset: the clock is Clk, and Rst is asynchronous and active-low.
REQ-016 The block SHALL write writeData into register writeReg on the rising edge of Clk when regWrite=1 and writeReg!=0.
REQ-017 Register 0 SHALL read as 0 at all times; writes to address 0 are discarded and do not increment writeCount.
REQ-018 Read ports SHALL be combinational, so readData1, readData2 and dbgData follow their address inputs with zero-cycle latency.
REQ-019 A write SHALL be visible on any read port from the cycle after the committing edge, subject to REQ-027.
REQ-020 writeCount SHALL increment by 1 on each committed write and wrap from 0xFFFF to 0x0000.
REQ-021 When regWrite=0, register contents and writeCount SHALL hold.
REQ-022 Both read ports and the debug port MAY address the same register simultaneously, and all SHALL return identical data.

Reset
REQ-023 While Rst=0, all 32 registers SHALL clear to 0 immediately, independent of Clk, and writeCount SHALL clear to 0.
REQ-024 All read outputs SHALL therefore read 0 during reset.
REQ-025 A write coinciding with reset assertion SHALL be lost.
REQ-026 The first write after deassertion SHALL occur on the first rising Clk edge with Rst=1 and regWrite=1.

Configuration
REQ-027 When the macro REGFILE_BYPASS_EN is defined, a read whose address equals writeReg while regWrite=1 and writeReg!=0 SHALL return writeData in the same cycle (write-through); this applies to readData1, readData2 and dbgData.
REQ-028 When REGFILE_BYPASS_EN is undefined, such a read SHALL return the old register value until the committing edge.

Structure
REQ-029 The shared package SHALL hold DATA_W, ADDR_W, the register-count constant, and the REG_ZERO address constant.
REQ-030 A single sub-module, regfile_read_port, SHALL implement one read path, including the zero check and the optional bypass, and SHALL be instantiated three times.
REQ-031 Storage SHALL be a single array of 2**ADDR_W words of width DATA_W.

Verification
REQ-032 Reset: write 0xDEADBEEF to r5, then pulse Rst low mid-cycle -> readData1(r5)=0 immediately and writeCount=0.
REQ-033 Write/read: regWrite=1, writeReg=8, writeData=0x12345678 for one edge -> next cycle readData1(8)=readData2(8)=dbgData(8)=0x12345678 and writeCount=1.
REQ-034 Zero register: regWrite=1, writeReg=0, writeData=0xFFFFFFFF -> readData1(0)=0 and writeCount unchanged.
REQ-035 Same-cycle read of the address being written (r3 old=0x1, new=0x2): with REGFILE_BYPASS_EN -> readData1=0x2 before the edge; without it -> 0x1 before the edge and 0x2 after.
REQ-036 Hold: regWrite=0 with writeData toggling for 10 cycles -> all registers and writeCount unchanged.
REQ-037 Counter wrap: 65536 committed writes -> writeCount=0x0000.
